// File: rtl/pair_seq_pkg.sv
// Shared types and defaults for the pair sequence checker.
// Optional delta check is enabled by defining PAIR_SEQ_CHK_DELTA_EN.
package pair_seq_pkg;

    localparam int WIDTH_DEF      = 5;
    localparam int DELTA_DEF      = 10;
    localparam int LOSS_LIMIT_DEF = 3;
    localparam int CNT_W_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_e;

    function automatic logic [31:0] wrap_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (v + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/pair_seq_checker_if.sv
// Counter-stream bundle: one (a, b) sample per valid cycle.
// No backpressure; the consumer accepts every sample.
interface pair_seq_checker_if
    import pair_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    modport master (output in_valid, output in_a, output in_b);
    modport slave  (input in_valid, input in_a, input in_b);

endinterface

// File: rtl/pair_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr wins over inc.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pair_seq_checker.sv
// Receive-side checker for the dual-counter stream (a, b both +1 per sample).
// Define PAIR_SEQ_CHK_DELTA_EN to also require (b - a) mod 2^WIDTH == DELTA.
module pair_seq_checker
    import pair_seq_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DELTA      = DELTA_DEF,
    parameter int LOSS_LIMIT = LOSS_LIMIT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    pair_seq_checker_if.slave    s,
    output logic                 locked,
    output logic                 match,
    output logic                 err,
    output logic [WIDTH-1:0]     exp_a,
    output logic [WIDTH-1:0]     exp_b,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [3:0] LIMIT = 4'(LOSS_LIMIT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_a_q, exp_a_d;
    logic [WIDTH-1:0] exp_b_q, exp_b_d;
    logic [3:0]       miss_q, miss_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;

    logic             seq_bad;
    logic             delta_bad;
    logic             bad;
    logic [3:0]       miss_inc;

    assign seq_bad  = (s.in_a != exp_a_q) || (s.in_b != exp_b_q);
    assign miss_inc = miss_q + 4'd1;

`ifdef PAIR_SEQ_CHK_DELTA_EN
    logic [WIDTH-1:0] diff;
    assign diff      = s.in_b - s.in_a;
    assign delta_bad = (diff != WIDTH'(DELTA));
`else
    assign delta_bad = 1'b0;
`endif

    assign bad = seq_bad || delta_bad;

    always_comb begin
        state_d = state_q;
        exp_a_d = exp_a_q;
        exp_b_d = exp_b_q;
        miss_d  = miss_q;
        match_d = 1'b0;
        err_d   = 1'b0;
        if (clr) begin
            state_d = IDLE;
            exp_a_d = '0;
            exp_b_d = '0;
            miss_d  = '0;
        end else if (s.in_valid) begin
            // Always follow the received values so a slip recovers in one sample.
            exp_a_d = WIDTH'(wrap_inc(32'(s.in_a), WIDTH));
            exp_b_d = WIDTH'(wrap_inc(32'(s.in_b), WIDTH));
            unique case (state_q)
                IDLE: begin
                    if (delta_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (bad) begin
                        err_d   = 1'b1;
                        miss_d  = 4'd1;
                        state_d = RESYNC;
                        if (LIMIT <= 4'd1) begin
                            state_d = IDLE;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = 1'b1;
                    end
                end
                RESYNC: begin
                    if (bad) begin
                        err_d = 1'b1;
                        if (miss_inc >= LIMIT) begin
                            state_d = IDLE;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        match_d = 1'b1;
                        miss_d  = '0;
                        state_d = TRACK;
                    end
                end
                default: begin
                    state_d = IDLE;
                    miss_d  = '0;
                end
            endcase
        end
        locked_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            miss_q   <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            miss_q   <= miss_d;
            match_q  <= match_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (s.in_valid),
        .cnt   (sample_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (err_d),
        .cnt   (err_cnt)
    );

    assign locked = locked_q;
    assign match  = match_q;
    assign err    = err_q;
    assign exp_a  = exp_a_q;
    assign exp_b  = exp_b_q;

endmodule

// File: tb/tb_pair_seq_checker.sv
// Randomized bench for pair_seq_checker against a lock/miss-count model.
// Honours PAIR_SEQ_CHK_DELTA_EN the same way as the design.
module tb_pair_seq_checker;

    localparam int W   = 5;
    localparam int M   = 32;
    localparam int DLT = 10;
    localparam int LIM = 3;
    localparam int CMAX = 255;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       locked, match, err;
    logic [4:0] exp_a, exp_b;
    logic [7:0] sample_cnt, err_cnt;

    pair_seq_checker_if #(.WIDTH(W)) s_if ();

    pair_seq_checker #(
        .WIDTH(W), .DELTA(DLT), .LOSS_LIMIT(LIM), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .s          (s_if.slave),
        .locked     (locked),
        .match      (match),
        .err        (err),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: "locked" plus a count of consecutive misses
    bit m_locked, m_match, m_err;
    int m_miss, m_ea, m_eb, m_scnt, m_ecnt;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic bit delta_bad(int a, int b);
`ifdef PAIR_SEQ_CHK_DELTA_EN
        return ((b - a + M) % M) != DLT;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_locked = 0; m_match = 0; m_err = 0;
        m_miss = 0; m_ea = 0; m_eb = 0;
        m_scnt = 0; m_ecnt = 0;
    endtask

    task automatic model(bit v, int a, int b, bit c);
        bit bad;
        m_match = 0;
        m_err   = 0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (m_scnt < CMAX) m_scnt++;
            bad = (a != m_ea) || (b != m_eb) || delta_bad(a, b);
            if (!m_locked) begin
                if (delta_bad(a, b)) begin
                    m_err = 1;
                    if (m_ecnt < CMAX) m_ecnt++;
                end else begin
                    m_locked = 1;
                end
            end else if (bad) begin
                m_err = 1;
                if (m_ecnt < CMAX) m_ecnt++;
                m_miss++;
                if (m_miss >= LIM) begin
                    m_locked = 0;
                    m_miss = 0;
                end
            end else begin
                m_match = 1;
                m_miss = 0;
            end
            m_ea = (a + 1) % M;
            m_eb = (b + 1) % M;
        end
    endtask

    task automatic cycle(bit v, int a, int b, bit c);
        @(negedge clk);
        s_if.in_valid = v;
        s_if.in_a = 5'(a);
        s_if.in_b = 5'(b);
        clr = c;
        @(posedge clk);
        model(v, a, b, c);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; clr = 0;
        s_if.in_valid = 0; s_if.in_a = 0; s_if.in_b = 0;
        model_reset();
        #12;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %0d exp 0", locked); end
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %0d exp 0", match); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", err); end
        n_checks++; if (exp_a !== 5'd0) begin n_fail++; $display("FAIL reset_exp_a got %0d exp 0", exp_a); end
        n_checks++; if (exp_b !== 5'd0) begin n_fail++; $display("FAIL reset_exp_b got %0d exp 0", exp_b); end
        n_checks++; if (sample_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_scnt got %0d exp 0", sample_cnt); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ecnt got %0d exp 0", err_cnt); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_stream();
        int nm = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1, (10 + i) % M, (20 + i) % M, 0);
            if (match === 1'b1) nm++;
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stream_locked[%0d] got %0d exp 1", i, locked); end
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stream_err[%0d] got %0d exp 0", i, err); end
            n_checks++; if (exp_a !== 5'(m_ea)) begin n_fail++; $display("FAIL stream_exp_a[%0d] got %0d exp %0d", i, exp_a, m_ea); end
        end
        n_checks++; if (nm != 29) begin n_fail++; $display("FAIL stream_matches got %0d exp 29", nm); end
        n_checks++; if (sample_cnt !== 8'd30) begin n_fail++; $display("FAIL stream_scnt got %0d exp 30", sample_cnt); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL stream_ecnt got %0d exp 0", err_cnt); end
        n_checks++; if (exp_a !== 5'd8) begin n_fail++; $display("FAIL stream_wrap_exp_a got %0d exp 8", exp_a); end
    endtask

    task automatic test_resync();
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 10 + i, 20 + i, 0);
        cycle(1, 15, 24, 0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL resync_err got %0d exp 1", err); end
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL resync_ecnt got %0d exp 1", err_cnt); end
        n_checks++; if (exp_a !== 5'd16) begin n_fail++; $display("FAIL resync_exp_a got %0d exp 16", exp_a); end
        n_checks++; if (exp_b !== 5'd25) begin n_fail++; $display("FAIL resync_exp_b got %0d exp 25", exp_b); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL resync_locked got %0d exp 1", locked); end
        cycle(1, 16, 25, 0);
`ifdef PAIR_SEQ_CHK_DELTA_EN
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL resync_delta_err got %0d exp 1", err); end
`else
        n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL resync_match got %0d exp 1", match); end
`endif
        n_checks++; if (match !== m_match) begin n_fail++; $display("FAIL resync_model_match got %0d exp %0d", match, m_match); end
    endtask

    task automatic test_loss();
        cycle(1, 0, 0, 1);
        cycle(1, 0, 10, 0);
        cycle(1, 1, 11, 0);
        cycle(1, 5, 9, 0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL loss_err1 got %0d exp 1", err); end
        cycle(1, 1, 30, 0);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_locked2 got %0d exp 1", locked); end
        cycle(1, 20, 2, 0);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_locked3 got %0d exp 0", locked); end
        n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL loss_ecnt got %0d exp 3", err_cnt); end
        cycle(1, 7, 17, 0);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_relock got %0d exp 1", locked); end
        n_checks++; if ({match, err} !== 2'b00) begin n_fail++; $display("FAIL loss_capture_pulse got %0b exp 00", {match, err}); end
    endtask

    task automatic test_clr();
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 4 + i, 14 + i, 0);
        cycle(1, 7, 17, 1);
        n_checks++; if (sample_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_scnt got %0d exp 0", sample_cnt); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked got %0d exp 0", locked); end
        n_checks++; if (exp_a !== 5'd0) begin n_fail++; $display("FAIL clr_exp_a got %0d exp 0", exp_a); end
        n_checks++; if ({match, err} !== 2'b00) begin n_fail++; $display("FAIL clr_pulse got %0b exp 00", {match, err}); end
        cycle(1, 8, 18, 0);
        cycle(1, 2, 3, 0);
        #2;
        rst_n = 0;
        s_if.in_valid = 0;
        model_reset();
        #1;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL async_locked got %0d exp 0", locked); end
        n_checks++; if (sample_cnt !== 8'd0) begin n_fail++; $display("FAIL async_scnt got %0d exp 0", sample_cnt); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL async_ecnt got %0d exp 0", err_cnt); end
        n_checks++; if (exp_b !== 5'd0) begin n_fail++; $display("FAIL async_exp_b got %0d exp 0", exp_b); end
        #1;
        rst_n = 1;
        cycle(1, 9, 19, 0);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL async_recapture got %0d exp 1", locked); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL async_recapture_err got %0d exp 0", err); end
    endtask

    task automatic test_delta();
        cycle(1, 0, 0, 1);
        cycle(1, 3, 13, 0);
        cycle(1, 4, 15, 0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL delta_err got %0d exp 1", err); end
        n_checks++; if (exp_b !== 5'd16) begin n_fail++; $display("FAIL delta_exp_b got %0d exp 16", exp_b); end
        n_checks++; if (exp_a !== 5'd5) begin n_fail++; $display("FAIL delta_exp_a got %0d exp 5", exp_a); end
        cycle(1, 20, 3, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 6, 25, 0);
        n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL delta_idle_err got %0d exp %0d", err, m_err); end
        n_checks++; if (locked !== m_locked) begin n_fail++; $display("FAIL delta_idle_locked got %0d exp %0d", locked, m_locked); end
    endtask

    task automatic test_random();
        int ca, cb, r;
        bit v, c;
        cycle(1, 0, 0, 1);
        ca = 0; cb = DLT;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            v = (r != 0);
            c = (r == 1);
            if (r == 2 || r == 3) begin
                ca = $urandom_range(0, M - 1);
                cb = (r == 2) ? (ca + DLT) % M : $urandom_range(0, M - 1);
            end else if (v) begin
                ca = (ca + 1) % M;
                cb = (cb + 1) % M;
            end
            cycle(v, ca, cb, c);
            n_checks++; if (locked !== m_locked) begin n_fail++; $display("FAIL rnd_locked[%0d] got %0d exp %0d", i, locked, m_locked); end
            n_checks++; if (match !== m_match) begin n_fail++; $display("FAIL rnd_match[%0d] got %0d exp %0d", i, match, m_match); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %0d exp %0d", i, err, m_err); end
            n_checks++; if (exp_a !== 5'(m_ea)) begin n_fail++; $display("FAIL rnd_exp_a[%0d] got %0d exp %0d", i, exp_a, m_ea); end
            n_checks++; if (exp_b !== 5'(m_eb)) begin n_fail++; $display("FAIL rnd_exp_b[%0d] got %0d exp %0d", i, exp_b, m_eb); end
            n_checks++; if (sample_cnt !== 8'(m_scnt)) begin n_fail++; $display("FAIL rnd_scnt[%0d] got %0d exp %0d", i, sample_cnt, m_scnt); end
            n_checks++; if (err_cnt !== 8'(m_ecnt)) begin n_fail++; $display("FAIL rnd_ecnt[%0d] got %0d exp %0d", i, err_cnt, m_ecnt); end
        end
    endtask

    task automatic test_saturate();
        int k = 0;
        cycle(1, 0, 0, 1);
        while (m_ecnt < CMAX && k < 2000) begin
            if (!m_locked) cycle(1, k % M, (k + DLT) % M, 0);
            else cycle(1, m_ea, (m_eb + 1) % M, 0);
            k++;
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL sat_err[%0d] got %0d exp %0d", k, err, m_err); end
        end
        n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d exp 255", err_cnt); end
        if (!m_locked) cycle(1, 1, 1 + DLT, 0);
        cycle(1, m_ea, (m_eb + 3) % M, 0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL sat_err_pulse got %0d exp 1", err); end
        n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_ecnt got %0d exp 255", err_cnt); end
        n_checks++; if (sample_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_scnt got %0d exp 255", sample_cnt); end
        n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL sat_match got %0d exp 0", match); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_resync();
        test_loss();
        test_clr();
        test_delta();
        test_random();
        test_saturate();
        cycle(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
